fetch_decode_ctrl: RTL and testbench
====================================

FETCH_DECODE_CTRL -- requirements
Module: fetch_decode_ctrl

Interface
REQ-001 clk  input  1  pipeline clock; all state updates on rising edge.
REQ-002 rst_n  input  1  reset, asynchronous, active-low.
REQ-003 PC_EN_IF  input  1  PC update enable from hazard detection; 0 = hold PC.
REQ-004 reg_FD_EN  input  1  IF/ID register enable; 0 = freeze IF/ID contents.
REQ-005 reg_FD_stall  input  1  IF/ID hold request (load-use stall).
REQ-006 reg_FD_flush  input  1  IF/ID bubble request (taken branch in ID).
REQ-007 Branch_ID  input  1  taken branch/jump resolved in ID.
REQ-008 PC_target_ID  input  32  branch/jump target from ID.
REQ-009 inst_IF  input  32  instruction word from instruction memory for PC_IF.
REQ-010 imem_ready  input  1  instruction memory handshake; 1 = inst_IF valid this cycle.
REQ-011 PC_IF  output  32  current fetch address, drives instruction memory.
REQ-012 PC_ID  output  32  PC of instruction held in IF/ID.
REQ-013 inst_ID  output  32  instruction held in IF/ID.
REQ-014 valid_ID  output  1  1 = inst_ID is a real instruction, 0 = bubble.
REQ-015 misalign_err  output  1  sticky flag, branch target with nonzero bits [1:0] accepted.
REQ-016 stall_cnt  output  16  saturating count of stall cycles.
REQ-017 flush_cnt  output  16  saturating count of flush bubbles inserted.
REQ-018 wait_cnt  output  16  saturating count of imem wait bubbles inserted.

Function
REQ-019 PC next-state priority: PC_EN_IF=0 -> hold; else Branch_ID=1 -> {PC_target_ID[31:2],2'b00}; else imem_ready=1 -> PC_IF+4; else hold.
REQ-020 PC_IF+4 wraps modulo 2^32 (0xFFFFFFFC -> 0x00000000), no error raised.
REQ-021 IF/ID next-state priority: reg_FD_EN=0 -> hold all; else reg_FD_stall=1 -> hold all; else reg_FD_flush=1 -> bubble; else imem_ready=0 -> bubble; else load inst_IF, PC_IF, valid_ID=1.
REQ-022 Bubble: inst_ID=0x00000013 (addi x0,x0,0), valid_ID=0, PC_ID=PC_IF.
REQ-023 Stall and flush asserted together: stall wins, IF/ID held, flush_cnt unchanged.
REQ-024 Branch_ID with PC_EN_IF=0: branch not taken that cycle; PC held; redirect occurs in first cycle PC_EN_IF=1 with Branch_ID still high.
REQ-025 Redirect takes effect 1 cycle: target appears on PC_IF the edge after Branch_ID & PC_EN_IF sampled high.
REQ-026 Normal fetch latency: inst at PC_IF with imem_ready=1 appears on inst_ID/PC_ID after 1 edge.
REQ-027 imem_ready=0 with no stall/flush: PC held, one bubble per wait cycle, same address re-presented until imem_ready=1.
REQ-028 misalign_err set when redirect taken with PC_target_ID[1:0]!=0; remains 1 until reset.
REQ-029 stall_cnt +1 each edge with reg_FD_EN=1 and reg_FD_stall=1.
REQ-030 flush_cnt +1 each edge a flush bubble loaded (REQ-021 flush branch).
REQ-031 wait_cnt +1 each edge an imem wait bubble loaded (REQ-021 imem branch).
REQ-032 All counters saturate at 0xFFFF; no wrap.
REQ-033 All outputs registered; no combinational path from any input to any output.

Reset
REQ-034 rst_n=0 asynchronously forces PC_IF=0x00000000, PC_ID=0x00000000, inst_ID=0x00000013, valid_ID=0, misalign_err=0, all counters 0.
REQ-035 Reset asserted mid-stall or mid-wait discards held state; first edge after rst_n rises fetches from 0x00000000 per REQ-019/021.
REQ-036 Deassertion is sampled at clk; no update on the edge coincident with rst_n still low.

Verification
REQ-037 Sequential fetch: imem_ready=1, inst_IF=0x00A00093 at PC 0 -> after 1 edge PC_ID=0, inst_ID=0x00A00093, valid_ID=1, PC_IF=4.
REQ-038 Load-use: PC_EN_IF=0, reg_FD_stall=1 for 1 cycle at PC_IF=8 -> PC_IF stays 8, IF/ID unchanged, stall_cnt=1.
REQ-039 Branch: Branch_ID=1, reg_FD_flush=1, PC_target_ID=0x40 at PC_IF=0x10 -> next PC_IF=0x40, valid_ID=0, inst_ID=0x00000013, flush_cnt=1.
REQ-040 Stall+branch: Branch_ID=1, PC_EN_IF=0, stall=1 one cycle then PC_EN_IF=1, flush=1 -> redirect on second edge only; stall_cnt=1, flush_cnt=1.
REQ-041 imem wait: imem_ready=0 for 3 cycles at PC_IF=0x20 -> PC_IF=0x20 throughout, 3 bubbles, wait_cnt=3; then normal fetch.
REQ-042 Boundaries: target 0x42 -> PC_IF=0x40, misalign_err=1; PC 0xFFFFFFFC wraps to 0; 70000 stall cycles -> stall_cnt=0xFFFF; rst_n low mid-stall -> all REQ-034 values immediately.

Source files
------------

// File: rtl/fetch_decode_ctrl.sv
// fetch_decode_ctrl: PC sequencing, IF/ID pipeline register and hazard event counters.
module fetch_decode_ctrl (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        PC_EN_IF,
  input  logic        reg_FD_EN,
  input  logic        reg_FD_stall,
  input  logic        reg_FD_flush,
  input  logic        Branch_ID,
  input  logic [31:0] PC_target_ID,
  input  logic [31:0] inst_IF,
  input  logic        imem_ready,
  output logic [31:0] PC_IF,
  output logic [31:0] PC_ID,
  output logic [31:0] inst_ID,
  output logic        valid_ID,
  output logic        misalign_err,
  output logic [15:0] stall_cnt,
  output logic [15:0] flush_cnt,
  output logic [15:0] wait_cnt
);
  localparam logic [31:0] NOP = 32'h0000_0013;
  logic [31:0] pc_if_q, pc_if_d, pc_id_q, pc_id_d, inst_id_q, inst_id_d;
  logic        valid_id_q, valid_id_d, misalign_q, misalign_d;
  logic [15:0] stall_cnt_q, stall_cnt_d, flush_cnt_q, flush_cnt_d, wait_cnt_q, wait_cnt_d;
  logic        hold, load;
  function automatic logic [15:0] sat_inc(input logic [15:0] c, input logic inc);
    return c + {15'd0, inc && c != 16'hFFFF};
  endfunction
  always_comb begin
    pc_if_d     = !PC_EN_IF ? pc_if_q :
                  Branch_ID ? {PC_target_ID[31:2], 2'b00} :
                  imem_ready ? pc_if_q + 32'd4 : pc_if_q;
    hold        = !reg_FD_EN || reg_FD_stall;
    load        = !hold && !reg_FD_flush && imem_ready;
    // bubbles and real loads both tag IF/ID with the current fetch address
    pc_id_d     = hold ? pc_id_q : pc_if_q;
    inst_id_d   = hold ? inst_id_q : load ? inst_IF : NOP;
    valid_id_d  = hold ? valid_id_q : load;
    misalign_d  = misalign_q || (PC_EN_IF && Branch_ID && PC_target_ID[1:0] != 2'b00);
    stall_cnt_d = sat_inc(stall_cnt_q, reg_FD_EN && reg_FD_stall);
    flush_cnt_d = sat_inc(flush_cnt_q, !hold && reg_FD_flush);
    wait_cnt_d  = sat_inc(wait_cnt_q, !hold && !reg_FD_flush && !imem_ready);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_if_q     <= '0;
      pc_id_q     <= '0;
      inst_id_q   <= NOP;
      valid_id_q  <= 1'b0;
      misalign_q  <= 1'b0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
      wait_cnt_q  <= '0;
    end else begin
      pc_if_q     <= pc_if_d;
      pc_id_q     <= pc_id_d;
      inst_id_q   <= inst_id_d;
      valid_id_q  <= valid_id_d;
      misalign_q  <= misalign_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
      wait_cnt_q  <= wait_cnt_d;
    end
  end
  assign PC_IF        = pc_if_q;
  assign PC_ID        = pc_id_q;
  assign inst_ID      = inst_id_q;
  assign valid_ID     = valid_id_q;
  assign misalign_err = misalign_q;
  assign stall_cnt    = stall_cnt_q;
  assign flush_cnt    = flush_cnt_q;
  assign wait_cnt     = wait_cnt_q;
endmodule

// File: tb/tb_fetch_decode_ctrl.sv
// tb_fetch_decode_ctrl: scoreboard bench; predicted state is queued at drive time and compared after each edge.
module tb_fetch_decode_ctrl;
  logic        clk = 0, rst_n = 0;
  logic        PC_EN_IF = 0, reg_FD_EN = 0, reg_FD_stall = 0, reg_FD_flush = 0, Branch_ID = 0, imem_ready = 0;
  logic [31:0] PC_target_ID = 0, inst_IF = 0;
  logic [31:0] PC_IF, PC_ID, inst_ID;
  logic        valid_ID, misalign_err;
  logic [15:0] stall_cnt, flush_cnt, wait_cnt;
  int          checks = 0, errors = 0;
  typedef struct {
    logic [31:0] pc_if, pc_id, inst;
    logic        valid, mis;
    logic [15:0] sc, fc, wc;
  } st_t;
  localparam st_t RST = '{32'h0, 32'h0, 32'h13, 1'b0, 1'b0, 16'h0, 16'h0, 16'h0};
  st_t m = RST;
  st_t q[$];
  fetch_decode_ctrl dut (
    .clk(clk), .rst_n(rst_n), .PC_EN_IF(PC_EN_IF), .reg_FD_EN(reg_FD_EN),
    .reg_FD_stall(reg_FD_stall), .reg_FD_flush(reg_FD_flush), .Branch_ID(Branch_ID),
    .PC_target_ID(PC_target_ID), .inst_IF(inst_IF), .imem_ready(imem_ready),
    .PC_IF(PC_IF), .PC_ID(PC_ID), .inst_ID(inst_ID), .valid_ID(valid_ID),
    .misalign_err(misalign_err), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt), .wait_cnt(wait_cnt)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", tag, act, exp);
    end
  endtask
  task automatic check_state(input string tag, input st_t e);
    check({tag, ".PC_IF"}, PC_IF, e.pc_if);
    check({tag, ".PC_ID"}, PC_ID, e.pc_id);
    check({tag, ".inst_ID"}, inst_ID, e.inst);
    check({tag, ".valid_ID"}, {31'd0, valid_ID}, {31'd0, e.valid});
    check({tag, ".misalign"}, {31'd0, misalign_err}, {31'd0, e.mis});
    check({tag, ".stall_cnt"}, {16'd0, stall_cnt}, {16'd0, e.sc});
    check({tag, ".flush_cnt"}, {16'd0, flush_cnt}, {16'd0, e.fc});
    check({tag, ".wait_cnt"}, {16'd0, wait_cnt}, {16'd0, e.wc});
  endtask
  // drive one cycle of inputs, predict the post-edge state, compare after the edge
  task automatic step(input string tag, input logic pc_en, en, st, fl, br,
                      input logic [31:0] tgt, inst, input logic rdy);
    st_t e;
    PC_EN_IF = pc_en; reg_FD_EN = en; reg_FD_stall = st; reg_FD_flush = fl;
    Branch_ID = br; PC_target_ID = tgt; inst_IF = inst; imem_ready = rdy;
    e = m;
    if (pc_en) begin
      if (br) begin
        e.pc_if = tgt & 32'hFFFF_FFFC;
        if (tgt[1:0] != 2'b00) e.mis = 1'b1;
      end else if (rdy) e.pc_if = m.pc_if + 32'd4;
    end
    if (en) begin
      if (st) begin
        if (m.sc != 16'hFFFF) e.sc = m.sc + 16'd1;
      end else if (fl || !rdy) begin
        e.pc_id = m.pc_if; e.inst = 32'h13; e.valid = 1'b0;
        if (fl && m.fc != 16'hFFFF) e.fc = m.fc + 16'd1;
        if (!fl && m.wc != 16'hFFFF) e.wc = m.wc + 16'd1;
      end else begin
        e.pc_id = m.pc_if; e.inst = inst; e.valid = 1'b1;
      end
    end
    q.push_back(e);
    m = e;
    @(posedge clk);
    #1;
    if (q.size() == 0) check({tag, ".queue"}, 32'd0, 32'd1);
    else check_state(tag, q.pop_front());
  endtask
  initial begin
    #22;
    check_state("reset", RST);
    rst_n = 1;
    step("seq0", 1, 1, 0, 0, 0, 0, 32'h00A00093, 1);
    check("r37.PC_IF", PC_IF, 32'h4);
    check("r37.inst_ID", inst_ID, 32'h00A00093);
    check("r37.valid", {31'd0, valid_ID}, 32'd1);
    step("seq1", 1, 1, 0, 0, 0, 0, 32'h00000111, 1);
    step("loaduse", 0, 1, 1, 0, 0, 0, 32'hDEADBEEF, 1);
    check("r38.PC_IF", PC_IF, 32'h8);
    check("r38.PC_ID", PC_ID, 32'h4);
    check("r38.inst_ID", inst_ID, 32'h111);
    check("r38.stall_cnt", {16'd0, stall_cnt}, 32'd1);
    step("seq2", 1, 1, 0, 0, 0, 0, 32'h00000222, 1);
    step("seq3", 1, 1, 0, 0, 0, 0, 32'h00000333, 1);
    step("branch", 1, 1, 0, 1, 1, 32'h40, 32'h00000444, 1);
    check("r39.PC_IF", PC_IF, 32'h40);
    check("r39.inst_ID", inst_ID, 32'h13);
    check("r39.valid", {31'd0, valid_ID}, 32'd0);
    check("r39.flush_cnt", {16'd0, flush_cnt}, 32'd1);
    step("stbr0", 0, 1, 1, 0, 1, 32'h80, 32'h00000555, 1);
    check("r40.hold_pc", PC_IF, 32'h40);
    step("stbr1", 1, 1, 0, 1, 1, 32'h80, 32'h00000666, 1);
    check("r40.redirect", PC_IF, 32'h80);
    check("r40.stall_cnt", {16'd0, stall_cnt}, 32'd2);
    check("r40.flush_cnt", {16'd0, flush_cnt}, 32'd2);
    step("to20", 1, 1, 0, 1, 1, 32'h20, 32'h0, 1);
    for (int i = 0; i < 3; i++) begin
      step("wait", 1, 1, 0, 0, 0, 0, 32'h00000777, 0);
      check("r41.PC_IF", PC_IF, 32'h20);
      check("r41.valid", {31'd0, valid_ID}, 32'd0);
    end
    check("r41.wait_cnt", {16'd0, wait_cnt}, 32'd3);
    step("after_wait", 1, 1, 0, 0, 0, 0, 32'h00000888, 1);
    check("r41.PC_ID", PC_ID, 32'h20);
    check("r41.inst_ID", inst_ID, 32'h888);
    step("misalign", 1, 1, 0, 1, 1, 32'h42, 32'h0, 1);
    check("r42.mis_pc", PC_IF, 32'h40);
    check("r42.mis_flag", {31'd0, misalign_err}, 32'd1);
    step("to_top", 1, 1, 0, 1, 1, 32'hFFFF_FFFC, 32'h0, 1);
    step("wrap", 1, 1, 0, 0, 0, 0, 32'h00000999, 1);
    check("r42.wrap_pc", PC_IF, 32'h0);
    check("r42.wrap_pcid", PC_ID, 32'hFFFF_FFFC);
    for (int i = 0; i < 300; i++)
      step("rand", $urandom_range(0, 3) != 0, $urandom_range(0, 4) != 0, $urandom_range(0, 4) == 0,
           $urandom_range(0, 4) == 0, $urandom_range(0, 5) == 0, $urandom, $urandom, $urandom_range(0, 3) != 0);
    for (int i = 0; i < 70000; i++)
      step("sat", 0, 1, 1, 0, 0, 0, 32'h0, 1);
    check("r42.stall_sat", {16'd0, stall_cnt}, 32'hFFFF);
    PC_EN_IF = 0; reg_FD_EN = 1; reg_FD_stall = 1; imem_ready = 1;
    #3 rst_n = 0;
    #1 m = RST;
    check_state("midreset", RST);
    #2 rst_n = 1;
    step("post_rst", 1, 1, 0, 0, 0, 0, 32'h00000ABC, 1);
    check("r35.PC_IF", PC_IF, 32'h4);
    check("r35.PC_ID", PC_ID, 32'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
